// File: rtl/down_counter_borrow_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_borrow_pkg
// Shared definitions for the down counter with borrow: the state encoding and
// the default counter width. The encodings match the ones the up counter uses,
// so waveforms from both counters read the same way.
// -----------------------------------------------------------------------------
package down_counter_borrow_pkg;

    // Default counter / data width in bits (must be at least 2).
    localparam int DEFAULT_WIDTH = 4;

    // Counter life cycle. IDLE after clear, RUN while counting,
    // DONE after a one-shot expiry.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : down_counter_borrow_pkg

// File: rtl/down_counter_borrow_zero_detect.sv
// -----------------------------------------------------------------------------
// down_counter_borrow_zero_detect
// Reduction-NOR zero detector. A single instance feeds both the borrow output
// and the step logic, so both always agree on what "zero" means.
//   val_i  : value under test (WIDTH bits)
//   zero_o : 1 when val_i == 0
// -----------------------------------------------------------------------------
module down_counter_borrow_zero_detect #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] val_i,
    output logic             zero_o
);

    assign zero_o = ~(|val_i);

endmodule : down_counter_borrow_zero_detect

// File: rtl/down_counter_borrow.sv
// -----------------------------------------------------------------------------
// down_counter_borrow
// Synchronous down counter with parallel load, two count enables, a reload
// register and a combinational borrow output for cascading.
//
// Ports:
//   clk_i   : clock, all state changes on the rising edge
//   clr_i   : synchronous active-high clear, overrides every other input
//   dic_i   : parallel load value (also captured as the reload value)
//   load_i  : synchronous load, wins over counting
//   enp_i   : enable parallel, gates stepping only
//   ent_i   : enable trickle, gates stepping and the borrow output
//   auto_i  : 1 = reload on the zero step, 0 = stop in DONE
//   qc_o    : counter value (registered)
//   bo_o    : borrow, combinational: ent & (qc == 0) & RUN
//   zp_o    : one-cycle pulse after every zero step (registered)
//   done_o  : high while in DONE (registered)
//   busy_o  : high while in RUN (registered)
//
// Cascade: bo_o of the low stage drives ent_i of the high stage, enp_i shared.
// -----------------------------------------------------------------------------
module down_counter_borrow
    import down_counter_borrow_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] dic_i,
    input  logic             load_i,
    input  logic             enp_i,
    input  logic             ent_i,
    input  logic             auto_i,
    output logic [WIDTH-1:0] qc_o,
    output logic             bo_o,
    output logic             zp_o,
    output logic             done_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] qc_q, qc_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    state_e           state_q, state_d;
    logic             zp_q, zp_d;
    logic             done_q;
    logic             busy_q;

    logic             qc_zero_s;
    logic             step_s;

    down_counter_borrow_zero_detect #(
        .WIDTH (WIDTH)
    ) u_zero_detect (
        .val_i  (qc_q),
        .zero_o (qc_zero_s)
    );

    // Stepping is only possible while running with both enables high;
    // load priority is resolved in the next-state block.
    assign step_s = (state_q == ST_RUN) & enp_i & ent_i;

    // Borrow is deliberately unregistered so a chained stage steps in the
    // same cycle the low stage performs its zero step.
    assign bo_o = ent_i & qc_zero_s & (state_q == ST_RUN);

    // Next-state logic: load, then step, then hold (clear handled at the flops).
    always_comb begin
        qc_d    = qc_q;
        rld_d   = rld_q;
        state_d = state_q;
        zp_d    = 1'b0;
        if (load_i) begin
            qc_d    = dic_i;
            rld_d   = dic_i;
            state_d = ST_RUN;
        end else if (step_s) begin
            if (!qc_zero_s) begin
                qc_d = qc_q - WIDTH'(1);
            end else if (auto_i) begin
                // Wrap: the zero step itself reloads, giving RLD+1 steps per pulse.
                qc_d = rld_q;
                zp_d = 1'b1;
            end else begin
                // Expire: count stays at zero, never wraps to all-ones.
                zp_d    = 1'b1;
                state_d = ST_DONE;
            end
        end else begin
            qc_d = qc_q;
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            qc_q    <= '0;
            rld_q   <= '0;
            state_q <= ST_IDLE;
            zp_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            qc_q    <= qc_d;
            rld_q   <= rld_d;
            state_q <= state_d;
            zp_q    <= zp_d;
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d == ST_RUN);
        end
    end

    assign qc_o   = qc_q;
    assign zp_o   = zp_q;
    assign done_o = done_q;
    assign busy_o = busy_q;

endmodule : down_counter_borrow

// File: tb/tb_down_counter_borrow.sv
module tb_down_counter_borrow;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       clr_i = 1'b1, load_i = 1'b0, enp_i = 1'b0, ent_i = 1'b0, auto_i = 1'b0;
    logic [3:0] dic_i = 4'd0;
    logic [3:0] qc_o;
    logic       bo_o, zp_o, done_o, busy_o;

    // cascade pair
    logic       c_clr = 1'b1, c_load = 1'b0, c_enp = 1'b0;
    logic [7:0] c_dic = 8'd0;
    logic [3:0] lo_qc, hi_qc;
    logic       lo_bo, lo_zp, lo_done, lo_busy;
    logic       hi_bo, hi_zp, hi_done, hi_busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    int m_qc = 0, m_rld = 0, m_st = M_IDLE, m_zp = 0;

    always #5 clk = ~clk;

    down_counter_borrow #(.WIDTH(4)) u_dut (
        .clk_i(clk), .clr_i(clr_i), .dic_i(dic_i), .load_i(load_i),
        .enp_i(enp_i), .ent_i(ent_i), .auto_i(auto_i),
        .qc_o(qc_o), .bo_o(bo_o), .zp_o(zp_o), .done_o(done_o), .busy_o(busy_o)
    );

    down_counter_borrow #(.WIDTH(4)) u_lo (
        .clk_i(clk), .clr_i(c_clr), .dic_i(c_dic[3:0]), .load_i(c_load),
        .enp_i(c_enp), .ent_i(1'b1), .auto_i(1'b1),
        .qc_o(lo_qc), .bo_o(lo_bo), .zp_o(lo_zp), .done_o(lo_done), .busy_o(lo_busy)
    );

    down_counter_borrow #(.WIDTH(4)) u_hi (
        .clk_i(clk), .clr_i(c_clr), .dic_i(c_dic[7:4]), .load_i(c_load),
        .enp_i(c_enp), .ent_i(lo_bo), .auto_i(1'b0),
        .qc_o(hi_qc), .bo_o(hi_bo), .zp_o(hi_zp), .done_o(hi_done), .busy_o(hi_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the counter rules at each rising edge.
    always @(posedge clk) begin
        if (clr_i) begin
            m_qc <= 0; m_rld <= 0; m_st <= M_IDLE; m_zp <= 0;
        end else if (load_i) begin
            m_qc <= int'(dic_i); m_rld <= int'(dic_i); m_st <= M_RUN; m_zp <= 0;
        end else if (m_st == M_RUN && enp_i && ent_i) begin
            if (m_qc > 0) begin
                m_qc <= m_qc - 1; m_zp <= 0;
            end else if (auto_i) begin
                m_qc <= m_rld; m_zp <= 1;
            end else begin
                m_st <= M_DONE; m_zp <= 1;
            end
        end else begin
            m_zp <= 0;
        end
    end

    // Compare process: checks every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("qc", int'(qc_o), m_qc);
            chk("zp", int'(zp_o), m_zp);
            chk("done", int'(done_o), int'(m_st == M_DONE));
            chk("busy", int'(busy_o), int'(m_st == M_RUN));
            chk("bo", int'(bo_o), int'(ent_i && m_qc == 0 && m_st == M_RUN));
        end
    end

    task automatic cyc(input logic clr, input logic load, input logic [3:0] dic,
                       input logic enp, input logic ent, input logic au);
        clr_i = clr; load_i = load; dic_i = dic; enp_i = enp; ent_i = ent; auto_i = au;
        @(posedge clk);
        #1;
    endtask

    task automatic ccyc(input logic clr, input logic load, input logic [7:0] dic, input logic enp);
        c_clr = clr; c_load = load; c_dic = dic; c_enp = enp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_qc [8];
        int exp_zp [8];
        exp_qc = '{1, 0, 2, 1, 0, 2, 1, 0};
        exp_zp = '{0, 0, 1, 0, 0, 1, 0, 0};

        // Clear for two cycles with enables asserted.
        cyc(1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);
        cmp_en = 1'b1;
        cyc(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
        chk("rst_qc", int'(qc_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_bo", int'(bo_o), 0);
        // Enables ignored in IDLE.
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("idle_qc", int'(qc_o), 0);
        chk("idle_busy", int'(busy_o), 0);

        // One-shot from 3.
        cyc(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        chk("os_load", int'(qc_o), 3);
        chk("os_busy", int'(busy_o), 1);
        for (int i = 2; i >= 0; i--) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            chk("os_qc", int'(qc_o), i);
        end
        chk("os_bo", int'(bo_o), 1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("os_zp", int'(zp_o), 1);
        chk("os_done", int'(done_o), 1);
        chk("os_busy0", int'(busy_o), 0);
        chk("os_qc0", int'(qc_o), 0);
        chk("os_model_st", m_st, M_DONE);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("os_zp_fall", int'(zp_o), 0);
        chk("os_bo_done", int'(bo_o), 0);

        // Auto-reload from 2.
        cyc(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1);
        chk("ar_load", int'(qc_o), 2);
        chk("ar_load_done", int'(done_o), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
            chk("ar_qc", int'(qc_o), exp_qc[i]);
            chk("ar_zp", int'(zp_o), exp_zp[i]);
            chk("ar_model_qc", m_qc, exp_qc[i]);
        end

        // Hold checks at 5.
        cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("hold_ent0", int'(qc_o), 5);
        chk("hold_bo", int'(bo_o), 0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("hold_enp0", int'(qc_o), 5);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("hold_step", int'(qc_o), 4);

        // Collisions.
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        chk("load_vs_step", int'(qc_o), 9);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        chk("clr_vs_load", int'(qc_o), 0);
        chk("clr_vs_load_busy", int'(busy_o), 0);
        chk("clr_vs_load_done", int'(done_o), 0);

        // RLD=0 auto-reload: ZP high on every enabled step.
        cyc(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
            chk("rld0_zp", int'(zp_o), 1);
            chk("rld0_qc", int'(qc_o), 0);
        end

        // AUTO changes mid-count only matter at the zero step.
        cyc(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("auto_late_qc", int'(qc_o), 2);
        chk("auto_late_busy", int'(busy_o), 1);

        // Load while DONE.
        cyc(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("expire_done", int'(done_o), 1);
        cyc(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        chk("reload_done", int'(done_o), 0);
        chk("reload_busy", int'(busy_o), 1);
        chk("reload_qc", int'(qc_o), 4);

        // CLR while RUN.
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("clr_run_qc", int'(qc_o), 0);
        chk("clr_run_busy", int'(busy_o), 0);

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
                4'($urandom_range(0, 15)), ($urandom_range(0, 5) != 0),
                ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
        end

        // Two-stage cascade: preload 8'h1F then count down to 8'h10.
        ccyc(1'b1, 1'b0, 8'h00, 1'b0);
        ccyc(1'b0, 1'b1, 8'h1F, 1'b0);
        chk("casc_load", int'({hi_qc, lo_qc}), 8'h1F);
        for (int i = 0; i < 15; i++) ccyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("casc_10", int'({hi_qc, lo_qc}), 8'h10);
        ccyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("casc_0f", int'({hi_qc, lo_qc}), 8'h0F);
        chk("casc_lo_zp", int'(lo_zp), 1);
        chk("casc_hi_zp0", int'(hi_zp), 0);
        for (int i = 0; i < 15; i++) ccyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("casc_00", int'({hi_qc, lo_qc}), 8'h00);
        chk("casc_bo", int'(lo_bo), 1);
        ccyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("casc_hi_zp", int'(hi_zp), 1);
        chk("casc_hi_done", int'(hi_done), 1);
        chk("casc_hi_qc", int'(hi_qc), 0);
        ccyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("casc_hi_zp_fall", int'(hi_zp), 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter_borrow
